// File: rtl/pll_drp_reconfig.sv
// pll_drp_reconfig: read-modify-write DRP sequencer that holds the PLL in reset while reprogramming it and waits for relock
module pll_drp_reconfig #(
  parameter int RST_CYCLES   = 4,
  parameter int DRP_TIMEOUT  = 1023,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [6:0]  i_req_addr,
  input  logic [15:0] i_req_mask,
  input  logic [15:0] i_req_data,
  input  logic        i_req_last,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [6:0]  o_drp_daddr,
  output logic        o_drp_den,
  output logic        o_drp_dwe,
  output logic [15:0] o_drp_di,
  input  logic [15:0] i_drp_do,
  input  logic        i_drp_drdy,
  output logic        o_pll_rst,
  input  logic        i_pll_locked
);
  localparam int MAX_A = (RST_CYCLES > DRP_TIMEOUT) ? RST_CYCLES : DRP_TIMEOUT;
  localparam int MAX_P = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
  localparam int CW = $clog2(MAX_P + 1);
  typedef enum logic [3:0] {IDLE, HOLD_RST, READ, WAIT_RD, WRITE, WAIT_WR, NEXT, RELEASE, WAIT_LOCK} state_t;
  state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [6:0] r_addr, r_daddr;
  logic [15:0] r_mask, r_data, r_di;
  logic r_last, r_ready, r_busy, r_done, r_error, r_den, r_dwe, r_pll_rst, r_lock_s1, r_lock_s2;
  logic w_accept;
  logic [CW-1:0] w_cnt_inc;
  assign w_accept = i_req_valid && r_ready;
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  assign o_req_ready = r_ready;
  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_error = r_error;
  assign o_drp_daddr = r_daddr;
  assign o_drp_den = r_den;
  assign o_drp_dwe = r_dwe;
  assign o_drp_di = r_di;
  assign o_pll_rst = r_pll_rst;
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_addr <= '0;
      r_mask <= '0;
      r_data <= '0;
      r_last <= 1'b0;
      r_ready <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_error <= 1'b0;
      r_den <= 1'b0;
      r_dwe <= 1'b0;
      r_daddr <= '0;
      r_di <= '0;
      r_pll_rst <= 1'b0;
      r_lock_s1 <= 1'b0;
      r_lock_s2 <= 1'b0;
    end else begin
      r_lock_s1 <= i_pll_locked;
      r_lock_s2 <= r_lock_s1;
      r_done <= 1'b0;
      r_den <= 1'b0;
      r_dwe <= 1'b0;
      r_cnt <= w_cnt_inc;
      case (r_state)
        IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_addr <= i_req_addr;
            r_mask <= i_req_mask;
            r_data <= i_req_data;
            r_last <= i_req_last;
            r_ready <= 1'b0;
            r_error <= 1'b0;
            r_busy <= 1'b1;
            r_pll_rst <= 1'b1;
            r_cnt <= '0;
            r_state <= HOLD_RST;
          end
        end
        HOLD_RST: if (r_cnt == CW'(RST_CYCLES - 1)) begin
          r_den <= 1'b1;
          r_daddr <= r_addr;
          r_state <= READ;
        end
        READ: begin
          r_cnt <= '0;
          r_state <= WAIT_RD;
        end
        WAIT_RD: if (i_drp_drdy) begin
          r_den <= 1'b1;
          r_dwe <= 1'b1;
          r_di <= (i_drp_do & r_mask) | (r_data & ~r_mask);
          r_state <= WRITE;
        end else if (r_cnt == CW'(DRP_TIMEOUT - 1)) begin
          r_error <= 1'b1;
          r_pll_rst <= 1'b0;
          r_busy <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        WRITE: begin
          r_cnt <= '0;
          r_state <= WAIT_WR;
        end
        WAIT_WR: if (i_drp_drdy) begin
          r_pll_rst <= !r_last;
          r_ready <= !r_last;
          r_state <= r_last ? RELEASE : NEXT;
        end else if (r_cnt == CW'(DRP_TIMEOUT - 1)) begin
          r_error <= 1'b1;
          r_pll_rst <= 1'b0;
          r_busy <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        NEXT: if (w_accept) begin
          r_addr <= i_req_addr;
          r_mask <= i_req_mask;
          r_data <= i_req_data;
          r_last <= i_req_last;
          r_ready <= 1'b0;
          r_den <= 1'b1;
          r_daddr <= i_req_addr;
          r_state <= READ;
        end
        RELEASE: begin
          r_cnt <= '0;
          r_state <= WAIT_LOCK;
        end
        WAIT_LOCK: if (r_lock_s2 || r_cnt == CW'(LOCK_TIMEOUT - 1)) begin
          r_done <= r_lock_s2;
          r_error <= !r_lock_s2;
          r_busy <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pll_drp_reconfig.sv
// tb_pll_drp_reconfig: randomized scoreboard bench with a behavioural DRP/PLL model and directed corner cases
module tb_pll_drp_reconfig;
  localparam int RST_CYCLES = 4, DRP_TIMEOUT = 1023, LOCK_TIMEOUT = 65535;
  localparam logic [1:0] E_RD = 2'd0, E_WR = 2'd1, E_DONE = 2'd2, E_ERR = 2'd3;
  typedef struct packed {logic [1:0] kind; logic [6:0] addr; logic [15:0] di;} exp_t;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, req_last = 0;
  logic [6:0] req_addr = 0, drp_daddr;
  logic [15:0] req_mask = 0, req_data = 0, drp_di, drp_do = 0;
  logic busy, done, error, drp_den, drp_dwe, drp_drdy = 0, pll_rst, pll_locked = 0;
  logic [15:0] pll_mem [128];
  logic [15:0] ref_mem [128];
  logic [15:0] do_hold = 0;
  exp_t exp_q [$];
  int checks = 0, errors = 0;
  int drdy_lat = 1, lock_lat = 10, pend = 0, lk_cnt = 0, rst_run = 0;
  bit mem_init = 0;
  logic err_prev = 0;
  always #5 clk = ~clk;
  pll_drp_reconfig #(.RST_CYCLES(RST_CYCLES), .DRP_TIMEOUT(DRP_TIMEOUT), .LOCK_TIMEOUT(LOCK_TIMEOUT)) dut (
    .i_clock(clk), .i_reset(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_addr(req_addr), .i_req_mask(req_mask), .i_req_data(req_data), .i_req_last(req_last),
    .o_busy(busy), .o_done(done), .o_error(error), .o_drp_daddr(drp_daddr), .o_drp_den(drp_den),
    .o_drp_dwe(drp_dwe), .o_drp_di(drp_di), .i_drp_do(drp_do), .i_drp_drdy(drp_drdy),
    .o_pll_rst(pll_rst), .i_pll_locked(pll_locked));
  function automatic logic [15:0] init_val(input int i);
    return (i == 8) ? 16'h1ABC : 16'(i * 40503 + 7);
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask
  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur as required", nm);
  endtask
  // DRP register file and lock behaviour of the PLL, driven away from the DUT clock edge
  always @(negedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 128; i++) pll_mem[i] = init_val(i);
      mem_init = 1;
    end
    drp_drdy = 0;
    drp_do = 16'($urandom);
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        drp_drdy = 1;
        drp_do = do_hold;
      end
    end
    if (drp_den) begin
      if (drp_dwe) pll_mem[drp_daddr] = drp_di;
      else do_hold = pll_mem[drp_daddr];
      pend = drdy_lat;
    end
    if (pll_rst) begin
      pll_locked = 0;
      lk_cnt = 0;
    end else if (lock_lat > 0) begin
      lk_cnt++;
      if (lk_cnt >= lock_lat) pll_locked = 1;
    end
  end
  // monitor: pops an expectation whenever the DUT issues a DRP access, a done pulse or a new error
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      err_prev = 0;
      rst_run = 0;
    end else begin
      rst_run = pll_rst ? rst_run + 1 : 0;
      if (drp_dwe && !drp_den) fail_now("dwe_without_den");
      if (drp_den) begin
        chk("den_rst_held", {31'd0, rst_run >= RST_CYCLES}, 32'd1);
        if (exp_q.size() == 0) fail_now("unexpected_den");
        else begin
          e = exp_q.pop_front();
          chk("drp_kind", {31'd0, drp_dwe}, {30'd0, e.kind});
          chk("drp_addr", {25'd0, drp_daddr}, {25'd0, e.addr});
          if (drp_dwe) chk("drp_di", {16'd0, drp_di}, {16'd0, e.di});
        end
      end
      if (done) begin
        if (exp_q.size() == 0) fail_now("unexpected_done");
        else begin
          e = exp_q.pop_front();
          chk("done_kind", {30'd0, E_DONE}, {30'd0, e.kind});
          chk("done_pll_rst", {31'd0, pll_rst}, 32'd0);
        end
      end
      if (error && !err_prev) begin
        if (exp_q.size() == 0) fail_now("unexpected_error");
        else begin
          e = exp_q.pop_front();
          chk("error_kind", {30'd0, E_ERR}, {30'd0, e.kind});
        end
      end
      err_prev = error;
    end
  end
  task automatic send(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d, input logic last, output logic ok);
    logic [15:0] nv;
    ok = 0;
    @(negedge clk);
    req_valid = 1; req_addr = a; req_mask = m; req_data = d; req_last = last;
    for (int i = 0; i < 400; i++) begin
      if (req_ready) begin
        @(posedge clk);
        #1 req_valid = 0;
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      req_valid = 0;
      fail_now("accept_timeout");
      return;
    end
    exp_q.push_back('{E_RD, a, 16'd0});
    if (drdy_lat == 0) exp_q.push_back('{E_ERR, 7'd0, 16'd0});
    else begin
      nv = (ref_mem[a] & m) | (d & ~m);
      ref_mem[a] = nv;
      exp_q.push_back('{E_WR, a, nv});
      if (last) exp_q.push_back('{(lock_lat > 0) ? E_DONE : E_ERR, 7'd0, 16'd0});
    end
  endtask
  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    fail_now("idle_timeout");
  endtask
  task automatic run_seq(input int n, input int gap);
    logic ok;
    for (int k = 0; k < n; k++) begin
      send(7'($urandom), 16'($urandom), 16'($urandom), k == n - 1, ok);
      if (!ok) return;
      repeat (gap) @(negedge clk);
    end
    wait_idle(400);
  endtask
  task automatic chk_reset_values(input string nm);
    chk(nm, {25'd0, req_ready, busy, done, error, drp_den, drp_dwe, pll_rst}, 32'd0);
    chk({nm, "_daddr"}, {25'd0, drp_daddr}, 32'd0);
    chk({nm, "_di"}, {16'd0, drp_di}, 32'd0);
  endtask
  initial begin
    logic ok;
    logic [15:0] prior, d;
    logic [6:0] a;
    int n;
    for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
    repeat (3) @(negedge clk);
    chk_reset_values("reset");
    rst = 0;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, req_ready}, 32'd1);
    // single entry from the worked example
    send(7'h08, 16'hF000, 16'h0145, 1, ok);
    wait_idle(200);
    chk("example_mem", {16'd0, pll_mem[8]}, 32'h1145);
    // three entries with idle gaps while waiting in NEXT
    run_seq(3, 5);
    // mask all ones keeps the register, mask all zeros replaces it
    prior = ref_mem[7'h10];
    send(7'h10, 16'hFFFF, 16'h5A5A, 1, ok);
    wait_idle(200);
    chk("mask_ffff", {16'd0, pll_mem[7'h10]}, {16'd0, prior});
    send(7'h11, 16'h0000, 16'hC3E1, 1, ok);
    wait_idle(200);
    chk("mask_0000", {16'd0, pll_mem[7'h11]}, 32'hC3E1);
    // DRDY never returns after the read
    drdy_lat = 0;
    send(7'h20, 16'h00FF, 16'h1234, 1, ok);
    n = 0;
    while (!error && n < 1300) begin
      @(negedge clk);
      n++;
    end
    chk("drp_timeout_window", {31'd0, n >= DRP_TIMEOUT && n <= DRP_TIMEOUT + RST_CYCLES + 8}, 32'd1);
    chk("drp_timeout_state", {29'd0, error, pll_rst, busy}, 32'b100);
    drdy_lat = 1;
    // lock never arrives after release
    lock_lat = 0;
    send(7'h21, 16'h0F0F, 16'hBEEF, 1, ok);
    n = 0;
    for (int i = 0; i < 70000 && !error; i++) begin
      @(negedge clk);
      if (busy && !pll_rst) n++;
    end
    chk("lock_timeout_window", {31'd0, n >= LOCK_TIMEOUT && n <= LOCK_TIMEOUT + 4}, 32'd1);
    chk("lock_timeout_state", {30'd0, error, busy}, 32'b10);
    lock_lat = 12;
    send(7'h22, 16'hFF00, 16'h00AA, 1, ok);
    @(negedge clk);
    chk("error_cleared", {31'd0, error}, 32'd0);
    wait_idle(200);
    // reset asserted while waiting for the write acknowledge
    drdy_lat = 3;
    send(7'h30, 16'h0000, 16'h7777, 1, ok);
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (drp_den && drp_dwe) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now("write_not_seen");
    @(negedge clk);
    rst = 1;
    exp_q.delete();
    @(negedge clk);
    chk_reset_values("midseq_reset");
    rst = 0;
    @(negedge clk);
    chk("ready_after_midseq_reset", {31'd0, req_ready}, 32'd1);
    // randomized sequences
    for (int s = 0; s < 25; s++) begin
      drdy_lat = $urandom_range(1, 4);
      lock_lat = $urandom_range(1, 20);
      run_seq($urandom_range(1, 4), $urandom_range(0, 3));
    end
    a = 7'($urandom);
    d = 16'($urandom);
    send(a, 16'h0000, d, 1, ok);
    wait_idle(200);
    chk("final_mem", {16'd0, pll_mem[a]}, {16'd0, d});
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
